// File: rtl/e_stage_reg_pkg.sv
// Shared pipeline constants and helpers for the execute-stage register.
// The E-register update decision is kept as a named enum so it reads clearly in the top module.
package e_stage_reg_pkg;

    localparam int PIPE_DATA_W     = 32;
    localparam int PIPE_ALU_CTRL_W = 3;
    localparam int REG_IDX_W       = 5;
    localparam int BUBBLE_CNT_W    = 16;

    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_CNT_MAX = '1;

    typedef enum logic [1:0] {
        E_LOAD   = 2'd0,
        E_HOLD   = 2'd1,
        E_BUBBLE = 2'd2
    } e_action_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
        if (v == BUBBLE_CNT_MAX) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/e_stage_reg_lu_hazard.sv
// Load-use hazard detector: a valid load in E whose destination feeds a source of D.
// Register $0 never produces a hazard since it is hard-wired to zero.
module lu_hazard
    import e_stage_reg_pkg::*;
(
    input  logic                 validE,
    input  logic                 dm2regE,
    input  logic                 we_regE,
    input  logic [REG_IDX_W-1:0] rtE,
    input  logic [REG_IDX_W-1:0] rsD,
    input  logic [REG_IDX_W-1:0] rtD,
    output logic                 hazard
);

    logic e_is_load;
    logic rt_nonzero;
    logic src_match;

    always_comb begin
        e_is_load  = validE & dm2regE & we_regE;
        rt_nonzero = (rtE != '0);
        src_match  = (rtE == rsD) | (rtE == rtD);
        hazard     = e_is_load & rt_nonzero & src_match;
    end

endmodule

// File: rtl/e_stage_reg.sv
// Decode-to-execute pipeline register, captured on the falling clock edge, with
// load-use bubble insertion, flush/stall control and a saturating bubble counter.
module e_stage_reg
    import e_stage_reg_pkg::*;
#(
    parameter int DATA_W     = PIPE_DATA_W,
    parameter int ALU_CTRL_W = PIPE_ALU_CTRL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_e,
    input  logic                    flush_e,

    input  logic [DATA_W-1:0]       pc_plus4D,
    input  logic [DATA_W-1:0]       rd1D,
    input  logic [DATA_W-1:0]       rd2D,
    input  logic [DATA_W-1:0]       sext_immD,
    input  logic [REG_IDX_W-1:0]    rsD,
    input  logic [REG_IDX_W-1:0]    rtD,
    input  logic [REG_IDX_W-1:0]    rdD,
    input  logic [REG_IDX_W-1:0]    shamtD,
    input  logic                    we_regD,
    input  logic                    we_dmD,
    input  logic                    dm2regD,
    input  logic                    reg_dstD,
    input  logic                    alu_srcD,
    input  logic                    jal_dstD,
    input  logic [ALU_CTRL_W-1:0]   alu_ctrlD,

    output logic [DATA_W-1:0]       pc_plus4E,
    output logic [DATA_W-1:0]       rd1E,
    output logic [DATA_W-1:0]       rd2E,
    output logic [DATA_W-1:0]       sext_immE,
    output logic [REG_IDX_W-1:0]    rsE,
    output logic [REG_IDX_W-1:0]    rtE,
    output logic [REG_IDX_W-1:0]    rdE,
    output logic [REG_IDX_W-1:0]    shamtE,
    output logic                    we_regE,
    output logic                    we_dmE,
    output logic                    dm2regE,
    output logic                    reg_dstE,
    output logic                    alu_srcE,
    output logic                    jal_dstE,
    output logic [ALU_CTRL_W-1:0]   alu_ctrlE,

    output logic                    validE,
    output logic                    stall_fd,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    logic      hazard;
    e_action_t action;
    logic      insert_bubble;

    lu_hazard u_lu_hazard (
        .validE  (validE),
        .dm2regE (dm2regE),
        .we_regE (we_regE),
        .rtE     (rtE),
        .rsD     (rsD),
        .rtD     (rtD),
        .hazard  (hazard)
    );

    // Priority: flush squashes even a stalled E; a hazard only bubbles when E may advance.
    always_comb begin
        action = E_LOAD;
        if (flush_e) begin
            action = E_BUBBLE;
        end else if (stall_e) begin
            action = E_HOLD;
        end else if (hazard) begin
            action = E_BUBBLE;
        end
    end

    always_comb begin
        insert_bubble = (action == E_BUBBLE);
        stall_fd      = (hazard | stall_e) & ~flush_e & ~rst;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pc_plus4E <= '0;
            rd1E      <= '0;
            rd2E      <= '0;
            sext_immE <= '0;
            rsE       <= '0;
            rtE       <= '0;
            rdE       <= '0;
            shamtE    <= '0;
            we_regE   <= 1'b0;
            we_dmE    <= 1'b0;
            dm2regE   <= 1'b0;
            reg_dstE  <= 1'b0;
            alu_srcE  <= 1'b0;
            jal_dstE  <= 1'b0;
            alu_ctrlE <= '0;
            validE    <= 1'b0;
        end else begin
            case (action)
                E_LOAD: begin
                    pc_plus4E <= pc_plus4D;
                    rd1E      <= rd1D;
                    rd2E      <= rd2D;
                    sext_immE <= sext_immD;
                    rsE       <= rsD;
                    rtE       <= rtD;
                    rdE       <= rdD;
                    shamtE    <= shamtD;
                    we_regE   <= we_regD;
                    we_dmE    <= we_dmD;
                    dm2regE   <= dm2regD;
                    reg_dstE  <= reg_dstD;
                    alu_srcE  <= alu_srcD;
                    jal_dstE  <= jal_dstD;
                    alu_ctrlE <= alu_ctrlD;
                    validE    <= 1'b1;
                end
                E_BUBBLE: begin
                    pc_plus4E <= '0;
                    rd1E      <= '0;
                    rd2E      <= '0;
                    sext_immE <= '0;
                    rsE       <= '0;
                    rtE       <= '0;
                    rdE       <= '0;
                    shamtE    <= '0;
                    we_regE   <= 1'b0;
                    we_dmE    <= 1'b0;
                    dm2regE   <= 1'b0;
                    reg_dstE  <= 1'b0;
                    alu_srcE  <= 1'b0;
                    jal_dstE  <= 1'b0;
                    alu_ctrlE <= '0;
                    validE    <= 1'b0;
                end
                default: begin
                    // E_HOLD: every field keeps its value
                end
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (insert_bubble) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule

// File: tb/tb_e_stage_reg.sv
// Directed bench for e_stage_reg: reset, normal load, load-use bubbles, stall/flush,
// asynchronous reset mid-hazard and bubble counter saturation.
module tb_e_stage_reg;

    logic        clk;
    logic        rst;
    logic        stall_e;
    logic        flush_e;
    logic [31:0] pc_plus4D, rd1D, rd2D, sext_immD;
    logic [4:0]  rsD, rtD, rdD, shamtD;
    logic        we_regD, we_dmD, dm2regD, reg_dstD, alu_srcD, jal_dstD;
    logic [2:0]  alu_ctrlD;
    logic [31:0] pc_plus4E, rd1E, rd2E, sext_immE;
    logic [4:0]  rsE, rtE, rdE, shamtE;
    logic        we_regE, we_dmE, dm2regE, reg_dstE, alu_srcE, jal_dstE;
    logic [2:0]  alu_ctrlE;
    logic        validE;
    logic        stall_fd;
    logic [15:0] bubble_cnt;

    logic [156:0] e_all;
    assign e_all = {pc_plus4E, rd1E, rd2E, sext_immE, rsE, rtE, rdE, shamtE,
                    we_regE, we_dmE, dm2regE, reg_dstE, alu_srcE, jal_dstE, alu_ctrlE};

    int checks;
    int failures;

    e_stage_reg dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
        .pc_plus4D(pc_plus4D), .rd1D(rd1D), .rd2D(rd2D), .sext_immD(sext_immD),
        .rsD(rsD), .rtD(rtD), .rdD(rdD), .shamtD(shamtD),
        .we_regD(we_regD), .we_dmD(we_dmD), .dm2regD(dm2regD), .reg_dstD(reg_dstD),
        .alu_srcD(alu_srcD), .jal_dstD(jal_dstD), .alu_ctrlD(alu_ctrlD),
        .pc_plus4E(pc_plus4E), .rd1E(rd1E), .rd2E(rd2E), .sext_immE(sext_immE),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .shamtE(shamtE),
        .we_regE(we_regE), .we_dmE(we_dmE), .dm2regE(dm2regE), .reg_dstE(reg_dstE),
        .alu_srcE(alu_srcE), .jal_dstE(jal_dstE), .alu_ctrlE(alu_ctrlE),
        .validE(validE), .stall_fd(stall_fd), .bubble_cnt(bubble_cnt)
    );

    // Clock / reset: falling edges at 5, 15, 25, ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Step past the next capturing (falling) edge and settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [4:0] rs, input logic [4:0] rt, input logic dm2reg,
                           input logic we_reg, input logic [31:0] rd1);
        rsD       = rs;
        rtD       = rt;
        dm2regD   = dm2reg;
        we_regD   = we_reg;
        rd1D      = rd1;
        rd2D      = rd1 ^ 32'hFFFF_0000;
        pc_plus4D = 32'h0000_0400 + {27'd0, rs};
        sext_immD = 32'h0000_0010;
        rdD       = 5'd3;
        shamtD    = 5'd2;
        we_dmD    = 1'b0;
        reg_dstD  = 1'b1;
        alu_srcD  = 1'b1;
        jal_dstD  = 1'b0;
        alu_ctrlD = 3'd2;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_e = 1'b1; flush_e = 1'b0;
        drive_d(5'd7, 5'd8, 1'b1, 1'b1, 32'hDEAD_BEEF);
        tick();
        checks++;
        if (e_all !== '0 || validE !== 1'b0) begin
            failures++; $display("FAIL reset_e_fields: got e=%h valid=%b want 0", e_all, validE);
        end
        checks++;
        if (bubble_cnt !== 16'h0) begin
            failures++; $display("FAIL reset_cnt: got %h want 0000", bubble_cnt);
        end
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++; $display("FAIL reset_stall_fd: got %b want 0", stall_fd);
        end
        stall_e = 1'b0;
        #2 rst = 1'b0;
    endtask

    task automatic test_normal_load();
        drive_d(5'd5, 5'd6, 1'b0, 1'b1, 32'h1234_5678);
        tick();
        checks++;
        if (rd1E !== 32'h1234_5678 || rsE !== 5'd5 || validE !== 1'b1 || bubble_cnt !== 16'h0) begin
            failures++;
            $display("FAIL load_basic: got rd1=%h rs=%0d valid=%b cnt=%h want 12345678 5 1 0000",
                     rd1E, rsE, validE, bubble_cnt);
        end
        checks++;
        if (rd2E !== 32'hEDCB_5678 || pc_plus4E !== 32'h0000_0405 || sext_immE !== 32'h10 ||
            rtE !== 5'd6 || rdE !== 5'd3 || shamtE !== 5'd2 || we_regE !== 1'b1 ||
            reg_dstE !== 1'b1 || alu_srcE !== 1'b1 || alu_ctrlE !== 3'd2 || dm2regE !== 1'b0) begin
            failures++; $display("FAIL load_fields: got e=%h", e_all);
        end
    endtask

    task automatic test_load_use();
        // lw into $8, then a consumer reading $8 through rs
        drive_d(5'd1, 5'd8, 1'b1, 1'b1, 32'hAAAA_0001);
        tick();
        drive_d(5'd8, 5'd3, 1'b0, 1'b1, 32'hBBBB_0002);
        #1;
        checks++;
        if (stall_fd !== 1'b1) begin
            failures++; $display("FAIL lu_rs_stall_fd: got %b want 1", stall_fd);
        end
        tick();
        checks++;
        if (e_all !== '0 || validE !== 1'b0 || bubble_cnt !== 16'd1) begin
            failures++; $display("FAIL lu_rs_bubble: got e=%h valid=%b cnt=%h want 0 0 0001",
                                 e_all, validE, bubble_cnt);
        end
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++; $display("FAIL lu_after_bubble_stall_fd: got %b want 0", stall_fd);
        end
        tick();
        checks++;
        if (validE !== 1'b1 || rd1E !== 32'hBBBB_0002 || rsE !== 5'd8 || bubble_cnt !== 16'd1) begin
            failures++; $display("FAIL lu_rs_reload: got valid=%b rd1=%h rs=%0d cnt=%h want 1 bbbb0002 8 0001",
                                 validE, rd1E, rsE, bubble_cnt);
        end
        // lw into $9, consumer reading $9 through rt
        drive_d(5'd2, 5'd9, 1'b1, 1'b1, 32'hCCCC_0003);
        tick();
        drive_d(5'd4, 5'd9, 1'b0, 1'b1, 32'hDDDD_0004);
        #1;
        checks++;
        if (stall_fd !== 1'b1) begin
            failures++; $display("FAIL lu_rt_stall_fd: got %b want 1", stall_fd);
        end
        tick();
        checks++;
        if (validE !== 1'b0 || bubble_cnt !== 16'd2) begin
            failures++; $display("FAIL lu_rt_bubble: got valid=%b cnt=%h want 0 0002", validE, bubble_cnt);
        end
        tick();
        // load whose we_reg is off does not count as a producer
        drive_d(5'd2, 5'd10, 1'b1, 1'b0, 32'hEEEE_0005);
        tick();
        drive_d(5'd10, 5'd1, 1'b0, 1'b1, 32'hEEEE_0006);
        #1;
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++; $display("FAIL lu_no_wereg_stall_fd: got %b want 0", stall_fd);
        end
        tick();
        checks++;
        if (validE !== 1'b1 || rd1E !== 32'hEEEE_0006 || bubble_cnt !== 16'd2) begin
            failures++; $display("FAIL lu_no_wereg_load: got valid=%b rd1=%h cnt=%h want 1 eeee0006 0002",
                                 validE, rd1E, bubble_cnt);
        end
    endtask

    task automatic test_zero_reg();
        drive_d(5'd1, 5'd0, 1'b1, 1'b1, 32'h0000_1111);
        tick();
        drive_d(5'd0, 5'd0, 1'b0, 1'b1, 32'h0000_2222);
        #1;
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++; $display("FAIL zero_reg_stall_fd: got %b want 0", stall_fd);
        end
        tick();
        checks++;
        if (validE !== 1'b1 || rd1E !== 32'h0000_2222 || bubble_cnt !== 16'd2) begin
            failures++; $display("FAIL zero_reg_load: got valid=%b rd1=%h cnt=%h want 1 00002222 0002",
                                 validE, rd1E, bubble_cnt);
        end
    endtask

    task automatic test_stall_flush();
        drive_d(5'd11, 5'd12, 1'b0, 1'b1, 32'h5555_AAAA);
        tick();
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_d(5'd13 + 5'(i), 5'd14, 1'b0, 1'b1, 32'h7777_0000 + i);
            tick();
            checks++;
            if (rd1E !== 32'h5555_AAAA || rsE !== 5'd11 || validE !== 1'b1 ||
                stall_fd !== 1'b1 || bubble_cnt !== 16'd2) begin
                failures++;
                $display("FAIL stall_hold_%0d: got rd1=%h rs=%0d valid=%b stall_fd=%b cnt=%h want 5555aaaa 11 1 1 0002",
                         i, rd1E, rsE, validE, stall_fd, bubble_cnt);
            end
        end
        flush_e = 1'b1;
        #1;
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++; $display("FAIL flush_stall_fd: got %b want 0", stall_fd);
        end
        tick();
        checks++;
        if (validE !== 1'b0 || e_all !== '0 || bubble_cnt !== 16'd3) begin
            failures++; $display("FAIL flush_over_stall: got valid=%b e=%h cnt=%h want 0 0 0003",
                                 validE, e_all, bubble_cnt);
        end
        flush_e = 1'b0;
        stall_e = 1'b0;
    endtask

    task automatic test_flush_with_hazard();
        drive_d(5'd1, 5'd8, 1'b1, 1'b1, 32'h0101_0101);
        tick();
        drive_d(5'd8, 5'd8, 1'b0, 1'b1, 32'h0202_0202);
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        checks++;
        if (validE !== 1'b0 || bubble_cnt !== 16'd4) begin
            failures++; $display("FAIL flush_hazard_once: got valid=%b cnt=%h want 0 0004", validE, bubble_cnt);
        end
    endtask

    task automatic test_reset_mid_hazard();
        drive_d(5'd1, 5'd8, 1'b1, 1'b1, 32'h0303_0303);
        tick();
        drive_d(5'd8, 5'd2, 1'b0, 1'b1, 32'h0404_0404);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (e_all !== '0 || validE !== 1'b0 || bubble_cnt !== 16'h0 || stall_fd !== 1'b0) begin
            failures++; $display("FAIL async_reset: got e=%h valid=%b cnt=%h stall_fd=%b want all 0",
                                 e_all, validE, bubble_cnt, stall_fd);
        end
        #1 rst = 1'b0;
        tick();
        checks++;
        if (validE !== 1'b1 || rd1E !== 32'h0404_0404 || rsE !== 5'd8 || bubble_cnt !== 16'h0) begin
            failures++; $display("FAIL post_reset_load: got valid=%b rd1=%h rs=%0d cnt=%h want 1 04040404 8 0000",
                                 validE, rd1E, rsE, bubble_cnt);
        end
    endtask

    task automatic test_saturation();
        flush_e = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        checks++;
        if (bubble_cnt !== 16'hFFFE) begin
            failures++; $display("FAIL sat_preload: got %h want fffe", bubble_cnt);
        end
        tick();
        checks++;
        if (bubble_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL sat_reach: got %h want ffff", bubble_cnt);
        end
        tick();
        checks++;
        if (bubble_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL sat_hold: got %h want ffff", bubble_cnt);
        end
        flush_e = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_normal_load();
        test_load_use();
        test_zero_reg();
        test_stall_flush();
        test_flush_with_hazard();
        test_reset_mid_hazard();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
